// File: rtl/reg_mem_bank_pkg.sv
// Shared types, lane width and parity helper for the reg_mem_bank slice.
// Parity storage is enabled by defining REG_MEM_BANK_PARITY_EN.
package reg_mem_bank_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic even_par(
    input logic [LANE_W-1:0] i_d
  );
    return ^i_d;
  endfunction

endpackage

// File: rtl/reg_mem_lane.sv
// One byte lane of storage with a registered read port.
// Parity bit per entry exists only with REG_MEM_BANK_PARITY_EN.
module reg_mem_lane
  import reg_mem_bank_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [LANE_W-1:0]    i_wdata,
  input  logic                 i_winj,
  input  logic                 i_load,
  input  logic                 i_rd,
  output logic [LANE_W-1:0]    o_rdata,
  output logic                 o_perr
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [LANE_W-1:0] r_mem [DEPTH];
  logic [LANE_W-1:0] r_rdata;
  logic              r_perr;
  logic              w_perr;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

`ifdef REG_MEM_BANK_PARITY_EN
  logic r_par [DEPTH];

  // Injection flips the stored bit so the next read flags this entry.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_par[i_addr] <= even_par(i_wdata) ^ i_winj;
    end
  end

  assign w_perr = even_par(r_mem[i_addr]) ^ r_par[i_addr];
`else
  logic w_unused;

  assign w_unused = i_winj;
  assign w_perr   = 1'b0;
`endif

  // Write responses load zeros so the payload is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_perr  <= 1'b0;
    end else if (i_load) begin
      r_rdata <= i_rd ? r_mem[i_addr] : '0;
      r_perr  <= i_rd & w_perr;
    end
  end

  assign o_rdata = r_rdata;
  assign o_perr  = r_perr;

endmodule

// File: rtl/reg_mem_bank.sv
// Byte-lane register memory with hardware clear and registered responses.
// Optional per-lane parity: define REG_MEM_BANK_PARITY_EN.
module reg_mem_bank
  import reg_mem_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  output logic                         busy,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wen,
  input  logic [ADDR_BITS-1:0]         req_addr,
  input  logic [DATA_WIDTH/LANE_W-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  input  logic                         par_inject,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err
);

  localparam int LANES = DATA_WIDTH / LANE_W;
  localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

  state_e               r_state;
  logic [ADDR_BITS-1:0] r_ptr;
  logic                 r_rsp_valid;

  logic                 w_clr_wr;
  logic                 w_acc;
  logic [ADDR_BITS-1:0] w_addr;
  logic [LANES-1:0]     w_perr;

  assign w_clr_wr  = (r_state == CLEAR);
  assign busy      = w_clr_wr;
  assign req_ready = (r_state == RUN) && !clr &&
                     (!r_rsp_valid || rsp_ready);
  assign w_acc     = req_valid && req_ready;
  assign w_addr    = w_clr_wr ? r_ptr : req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_rsp_valid <= 1'b0;
          if (clr) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == PTR_LAST) begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (clr) begin
            r_state     <= CLEAR;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
          end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic              w_we;
    logic [LANE_W-1:0] w_wdata;
    logic              w_inj;

    assign w_we    = w_clr_wr |
                     (w_acc & req_wen & req_be[i]);
    assign w_wdata = w_clr_wr ? '0 :
                     req_wdata[i*LANE_W +: LANE_W];
    // Only lane 0 carries the injected parity fault.
    if (i == 0) begin : g_inj
      assign w_inj = !w_clr_wr && par_inject;
    end else begin : g_noinj
      assign w_inj = 1'b0;
    end

    reg_mem_lane #(
      .ADDR_BITS(ADDR_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_we),
      .i_addr (w_addr),
      .i_wdata(w_wdata),
      .i_winj (w_inj),
      .i_load (w_acc),
      .i_rd   (!req_wen),
      .o_rdata(rsp_rdata[i*LANE_W +: LANE_W]),
      .o_perr (w_perr[i])
    );
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = |w_perr;

endmodule

// File: tb/tb_reg_mem_bank.sv
// Scoreboard bench for reg_mem_bank at DATA_WIDTH=32, ADDR_BITS=5.
module tb_reg_mem_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        busy;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        par_inject = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [32:0] q[$];
  logic [31:0] m_data [32];
  logic        m_bad [32];
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  reg_mem_bank #(
    .DATA_WIDTH(32),
    .ADDR_BITS (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .par_inject(par_inject),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Inputs are stable from posedge+1 on, so negedge sees what the next edge sees.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rst || clr) begin
      q.delete();
      for (int i = 0; i < 32; i++) begin
        m_data[i] = '0;
        m_bad[i]  = 1'b0;
      end
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h/%b, none expected",
                   rsp_rdata, rsp_err);
        end else begin
          exp = q.pop_front();
          if ({rsp_rdata, rsp_err} !== exp) begin
            errors++;
            $display("FAIL rsp_payload got %h/%b want %h/%b",
                     rsp_rdata, rsp_err, exp[32:1], exp[0]);
          end
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
      if (req_valid && req_ready) begin
        if (req_wen) begin
          for (int l = 0; l < 4; l++) begin
            if (req_be[l]) m_data[req_addr][l*8 +: 8] = req_wdata[l*8 +: 8];
          end
`ifdef REG_MEM_BANK_PARITY_EN
          if (req_be[0]) m_bad[req_addr] = par_inject;
`endif
          q.push_back({32'h0, 1'b0});
        end else begin
          q.push_back({m_data[req_addr], m_bad[req_addr]});
        end
      end
    end
  end

  task automatic do_req(input logic wen, input logic [4:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input logic inj);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_wen = wen;
    req_addr = a;
    req_be = be;
    req_wdata = d;
    par_inject = inj;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout addr %0d ready %b want 1", a, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    par_inject = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", q.size());
    end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s busy cycles %0d want 32", name, n);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after_clear %b want 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b0100 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state rdy/busy/vld/err %b%b%b%b data %h want 0100 0",
               req_ready, busy, rsp_valid, rsp_err, rsp_rdata);
    end
    rst = 1'b0;
    count_busy("reset");
    for (int a = 0; a < 32; a++) do_req(1'b0, a[4:0], 4'h0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_byte_lanes();
    do_req(1'b1, 5'd3, 4'b1111, 32'hAABBCCDD, 1'b0);
    do_req(1'b1, 5'd3, 4'b0101, 32'h11223344, 1'b0);
    do_req(1'b0, 5'd3, 4'b0000, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_lanes got %h want aa22cc44", last_rdata);
    end
    do_req(1'b1, 5'd3, 4'b0000, 32'hFFFFFFFF, 1'b0);
    do_req(1'b0, 5'd3, 4'b0000, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL be_zero got %h want aa22cc44", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 5'd31, 4'b0001, 32'h0000005A, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_write_rsp vld %b data %h want 1 0", rsp_valid, rsp_rdata);
    end
    do_req(1'b0, 5'd31, 4'b0000, 32'h0, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A) begin
      errors++;
      $display("FAIL b2b_read_rsp vld %b data %h want 1 5a", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    do_req(1'b0, 5'd3, 4'b0000, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_wen = 1'b0;
    req_addr = 5'd31;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_rdata !== 32'hAA22CC44) begin
        errors++;
        $display("FAIL hold_%0d rdy %b vld %b data %h want 0 1 aa22cc44",
                 k, req_ready, rsp_valid, rsp_rdata);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A) begin
      errors++;
      $display("FAIL release_accept vld %b data %h want 1 5a", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_clear();
    do_req(1'b1, 5'd7, 4'b0001, 32'h77, 1'b0);
    drain();
    rsp_ready = 1'b0;
    do_req(1'b0, 5'd7, 4'b0000, 32'h0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_discard vld %b busy %b want 0 1", rsp_valid, busy);
    end
    count_busy("clr");
    do_req(1'b0, 5'd7, 4'b0000, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata !== 32'h0) begin
      errors++;
      $display("FAIL clr_read got %h want 0", last_rdata);
    end
    do_req(1'b1, 5'd9, 4'b1111, 32'hCAFEF00D, 1'b0);
    drain();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy %b rdy %b vld %b want 1 0 0",
               busy, req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy("rst_mid");
    do_req(1'b0, 5'd9, 4'b0000, 32'h0, 1'b0);
    do_req(1'b0, 5'd31, 4'b0000, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_parity();
    logic want;
`ifdef REG_MEM_BANK_PARITY_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_req(1'b1, 5'd2, 4'b0001, 32'h0F, 1'b1);
    do_req(1'b0, 5'd2, 4'b0000, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata !== 32'h0F || last_err !== want) begin
      errors++;
      $display("FAIL par_inject got %h/%b want 0000000f/%b",
               last_rdata, last_err, want);
    end
    do_req(1'b1, 5'd2, 4'b0001, 32'h0F, 1'b0);
    do_req(1'b0, 5'd2, 4'b0000, 32'h0, 1'b0);
    drain();
    checks++;
    if (last_rdata !== 32'h0F || last_err !== 1'b0) begin
      errors++;
      $display("FAIL par_rewrite got %h/%b want 0000000f/0",
               last_rdata, last_err);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom);
      req_wen = 1'($urandom);
      req_addr = 5'($urandom_range(0, 7));
      req_be = 4'($urandom);
      req_wdata = $urandom;
      par_inject = ($urandom_range(0, 7) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    par_inject = 1'b0;
    rsp_ready = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_mem_bank.md
# reg_mem_bank

Parametrised, byte-lane-writable register memory with a valid/ready request and response handshake. It adds hardware clear-on-reset, backpressured registered read responses, and optional per-byte parity. It sits between the datapath and any bus master that needs small, fast scratch storage. It supersedes the bare single-port register memory where ordered responses or byte writes are required.

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8; LANES = DATA_WIDTH/8
- ADDR_BITS, 5: address width; DEPTH = 2**ADDR_BITS words
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  single-cycle pulse; restarts the hardware clear sequence
- busy  out  1  high while the clear sequence runs
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_BITS  word address
- req_be  in  LANES  byte-lane write enables; ignored on reads
- req_wdata  in  DATA_WIDTH  write data
- par_inject  in  1  on an accepted write, invert the stored parity of lane 0; ignored without the parity macro
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; all zeros for write responses
- rsp_err  out  1  parity error on a read response

## Operation
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=CLEAR, clear pointer=0.
- State machine: CLEAR, then RUN.
  - CLEAR: each cycle writes zero, with correct parity, to every lane at the clear pointer, then increments the pointer.
  - After address DEPTH-1 is written, CLEAR moves to RUN.
  - The pending response is discarded on entry to CLEAR: rsp_valid=0.
- RUN, with clr=1: go to CLEAR, pointer=0, no request accepted that cycle.
- req_ready = (state==RUN) && !clr && (!rsp_valid || rsp_ready). The response register is one entry deep.
- Accepted write: for each lane i with req_be[i]=1, store req_wdata[8i+7:8i]. Lanes with req_be[i]=0 are unchanged. The response carries rsp_rdata=0 and rsp_err=0.
- Accepted write with req_be all zeros: memory unchanged; a response is still returned.
- Accepted read: the response carries the stored word at the acceptance edge.
- Read immediately following a write to the same address (next accepted cycle): returns the new data. No bypass is needed because accepts are one per cycle.
- Response holding: rsp_valid, rsp_rdata and rsp_err hold stable until consumed.
- Same-cycle consume and accept: rsp_valid stays 1 and the payload updates.
- Consume without a new accept: rsp_valid falls to 0.
- Addresses wrap naturally. Every ADDR_BITS value is valid.
- Reset mid-CLEAR or mid-RUN: immediate return to the reset values. The clear sequence restarts from address 0.

## Timing
- Response latency: rsp_valid rises 1 cycle after the acceptance edge.
- Sustained throughput: 1 request per cycle while rsp_ready=1.
- Clear: after rst deasserts, busy is high for exactly DEPTH cycles, then falls; req_ready may rise in the same cycle.
- clr asserted during RUN: busy rises on the following edge and stays high for DEPTH cycles.
- clr asserted during CLEAR: the sequence restarts from address 0.
- No combinational path from req_* to rsp_*. The only combinational path to req_ready is from rsp_ready and clr.

## Configuration
- REG_MEM_BANK_PARITY_EN defined:
  - Each lane stores 9 bits: data plus even parity.
  - A read recomputes parity per lane; rsp_err = OR of the per-lane mismatches.
  - par_inject corrupts the lane-0 parity of the written word.
- REG_MEM_BANK_PARITY_EN undefined:
  - No parity storage.
  - rsp_err is tied to 0.
  - par_inject is unused.

## Structure
- Package reg_mem_bank_pkg contains:
  - state enum {CLEAR, RUN}
  - LANE_W = 8
  - an even-parity function over LANE_W bits
- Sub-module reg_mem_lane: one byte lane's storage array. Contents:
  - write enable
  - optional parity bit under the same macro
  - registered read of data and parity mismatch
- reg_mem_bank instantiates LANES copies of reg_mem_lane and holds the FSM, clear pointer, handshake and response register.

## Test plan
- Reset, then wait: busy high for 32 cycles (defaults) -> read every address -> all return 0x00, rsp_err=0.
- DATA_WIDTH=32: write 0xAABBCCDD to address 3 with be=4'b1111, then write 0x11223344 to address 3 with be=4'b0101 -> read address 3 returns 0xAA22CC44.
- Write 0x5A to address 31, then read address 31 back-to-back with rsp_ready=1 -> responses on consecutive cycles: 0x00 (write), then 0x5A.
- Hold rsp_ready=0 after a read response -> req_ready=0; the response stays stable for 5 cycles. Raise rsp_ready -> the next request is accepted in the same cycle.
- Write 0x77 to address 7, pulse clr, wait -> busy for 32 cycles; read address 7 returns 0x00. Assert rst mid-clear -> busy stays high for the full 32 cycles after release.
- With REG_MEM_BANK_PARITY_EN: write 0x0F to address 2 with par_inject=1 -> read returns 0x0F with rsp_err=1. Rewrite without par_inject -> rsp_err=0.
